mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 reloj  in  1  clock; all state updates on its rising edge.
REQ-003 resetMEM  in  1  synchronous reset, active-high.
REQ-004 MEM_RD, MEM_WR, w_h  in  1 each  memory read, memory write, halfword select (0=word, 1=halfword).
REQ-005 ctrl_WB_mem  in  2  writeback control; DIR  in  32  ALU result/address; DI  in  32  store data; Y_MUX_mem  in  5  destination register.
REQ-006 mem_req  out  1, mem_we  out  1, mem_addr  out  32, mem_wdata  out  32, mem_be  out  4  external data-memory request bus.
REQ-007 mem_ack  in  1, mem_rdata  in  32  memory completion and read data.
REQ-008 stall  out  1  freezes the upstream pipeline register and earlier stages.
REQ-009 ctrl_WB_wb  out  2, DO_wb  out  32, DIR_wb  out  32, Y_MUX_wb  out  5  MEM/WB register outputs.
REQ-010 misalign  out  1, bus_err  out  1  one-cycle error pulses.

Function
REQ-011 access = MEM_RD | MEM_WR; when both are 1, SHALL treat the access as a write.
REQ-012 aligned = w_h ? (DIR[0]==0) : (DIR[1:0]==0); misaligned access SHALL generate no bus request, a misalign pulse the next cycle, and a bubble (ctrl_WB_wb=0).
REQ-013 FSM states IDLE, BUSY; IDLE->BUSY when access & aligned; BUSY->IDLE on mem_ack or timeout.
REQ-014 mem_req, mem_we, mem_addr, mem_wdata, mem_be SHALL be registered: loaded on the IDLE->BUSY edge, held constant throughout BUSY, mem_req=0 in IDLE.
REQ-015 mem_addr = {DIR[31:2],2'b00}.
REQ-016 Word store: mem_be=4'b1111, mem_wdata=DI; halfword store: mem_wdata={DI[15:0],DI[15:0]}, mem_be=DIR[1]?4'b1100:4'b0011.
REQ-017 Reads: mem_we=0, mem_be=4'b1111; halfword read data SHALL be sign-extended from mem_rdata[31:16] if DIR[1]=1, else from mem_rdata[15:0].
REQ-018 stall = (IDLE & access & aligned) | (BUSY & ~mem_ack & ~timeout), combinational.
REQ-019 Memory access latency: 2 cycles minimum (issue cycle + ack cycle); non-memory instruction: 1 cycle, stall=0.
REQ-020 MEM/WB register SHALL load {ctrl_WB_mem, read data or 0, DIR, Y_MUX_mem} on every edge with stall=0; DO_wb=0 for non-read instructions.
REQ-021 On edges with stall=1, ctrl_WB_wb SHALL load 2'b00 (bubble); DO_wb, DIR_wb, Y_MUX_wb hold.
REQ-022 Read data SHALL be captured from mem_rdata in the mem_ack cycle.
REQ-023 8-bit wait counter SHALL clear on entering BUSY, increment each BUSY cycle without ack; at count 255 (timeout) SHALL return to IDLE, pulse bus_err next cycle, deassert stall that cycle, and load a bubble.
REQ-024 mem_ack while IDLE SHALL be ignored.
REQ-025 mem_ack and timeout in the same cycle SHALL be treated as ack (no bus_err).
REQ-026 Back-to-back memory instructions SHALL each spend one IDLE issue cycle; no request overlap.

Reset
REQ-027 resetMEM SHALL force state IDLE, counter 0, and every output register to 0 (mem_req, mem_we, mem_addr, mem_wdata, mem_be, ctrl_WB_wb, DO_wb, DIR_wb, Y_MUX_wb, misalign, bus_err).
REQ-028 resetMEM during BUSY SHALL abandon the access; mem_req=0 the following cycle; a later mem_ack SHALL be ignored.
REQ-029 stall SHALL be 0 in the reset cycle.

Verification
REQ-030 Word read: MEM_RD=1, DIR=0x10, ack 3 cycles after issue with rdata=0xDEADBEEF -> mem_addr=0x10, be=1111, stall high 3 cycles, DO_wb=0xDEADBEEF, ctrl_WB_wb=ctrl_WB_mem.
REQ-031 Halfword store: MEM_WR=1, w_h=1, DIR=0x22, DI=0x0000ABCD -> mem_addr=0x20, be=1100, wdata=0xABCDABCD, mem_we=1.
REQ-032 Halfword read: w_h=1, DIR=0x06, rdata=0x8001_1234 -> DO_wb=0xFFFF8001; DIR=0x04 same rdata -> DO_wb=0x00001234.
REQ-033 Misaligned word read DIR=0x13 -> mem_req stays 0, stall=0, misalign pulses once, ctrl_WB_wb=00.
REQ-034 No ack for 255 BUSY cycles -> bus_err one pulse, FSM IDLE, bubble in WB, stall released.
REQ-035 resetMEM asserted mid-BUSY, ack arrives 2 cycles later -> all outputs 0, mem_req=0, ack ignored, next instruction proceeds normally.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: load/store stage with registered memory request bus, wait timeout and MEM/WB register
module mem_stage (
   input  logic        reloj,
   input  logic        resetMEM,
   input  logic        MEM_RD,
   input  logic        MEM_WR,
   input  logic        w_h,
   input  logic [1:0]  ctrl_WB_mem,
   input  logic [31:0] DIR,
   input  logic [31:0] DI,
   input  logic [4:0]  Y_MUX_mem,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        stall,
   output logic [1:0]  ctrl_WB_wb,
   output logic [31:0] DO_wb,
   output logic [31:0] DIR_wb,
   output logic [4:0]  Y_MUX_wb,
   output logic        misalign,
   output logic        bus_err
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;
   logic [0:0]  st;
   logic [7:0]  cnt;
   logic        hw_q, a1_q;
   logic        busy, access, aligned, go, timeout;
   logic [15:0] half;
   logic [31:0] rd_data;
   assign busy    = st == BUSY;
   assign access  = MEM_RD | MEM_WR;
   assign aligned = w_h ? ~DIR[0] : (DIR[1:0] == 2'b00);
   assign go      = ~busy & access & aligned;
   assign timeout = busy & (cnt == 8'hff);
   assign stall   = ~resetMEM & (go | (busy & ~mem_ack & ~timeout));
   assign half    = a1_q ? mem_rdata[31:16] : mem_rdata[15:0];
   assign rd_data = hw_q ? {{16{half[15]}}, half} : mem_rdata;
   always_ff @(posedge reloj) begin
      if (resetMEM) begin
         st         <= IDLE;
         cnt        <= 8'd0;
         hw_q       <= 1'b0;
         a1_q       <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 32'd0;
         mem_wdata  <= 32'd0;
         mem_be     <= 4'd0;
         ctrl_WB_wb <= 2'd0;
         DO_wb      <= 32'd0;
         DIR_wb     <= 32'd0;
         Y_MUX_wb   <= 5'd0;
         misalign   <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         misalign <= ~busy & access & ~aligned;
         bus_err  <= timeout & ~mem_ack;
         if (go) begin
            st        <= BUSY;
            cnt       <= 8'd0;
            hw_q      <= w_h;
            a1_q      <= DIR[1];
            mem_req   <= 1'b1;
            mem_we    <= MEM_WR;
            mem_addr  <= {DIR[31:2], 2'b00};
            mem_wdata <= w_h ? {DI[15:0], DI[15:0]} : DI;
            mem_be    <= (MEM_WR & w_h) ? (DIR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
         end else if (busy & (mem_ack | timeout)) begin
            st      <= IDLE;
            mem_req <= 1'b0;
         end else if (busy) begin
            cnt <= cnt + 8'd1;
         end
         // unstalled edges with no ack in BUSY are timeouts; in IDLE with an access, misaligned
         if (stall) begin
            ctrl_WB_wb <= 2'b00;
         end else begin
            ctrl_WB_wb <= ((busy & ~mem_ack) | (~busy & access)) ? 2'b00 : ctrl_WB_mem;
            DO_wb      <= (busy & mem_ack & ~mem_we) ? rd_data : 32'd0;
            DIR_wb     <= DIR;
            Y_MUX_wb   <= Y_MUX_mem;
         end
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage
module tb_mem_stage;
   logic        reloj = 1'b0;
   logic        resetMEM, MEM_RD, MEM_WR, w_h, mem_ack;
   logic [1:0]  ctrl_WB_mem;
   logic [31:0] DIR, DI, mem_rdata;
   logic [4:0]  Y_MUX_mem;
   logic        mem_req, mem_we, stall, misalign, bus_err;
   logic [31:0] mem_addr, mem_wdata, DO_wb, DIR_wb;
   logic [3:0]  mem_be;
   logic [1:0]  ctrl_WB_wb;
   logic [4:0]  Y_MUX_wb;
   logic [70:0] wb_now, sb[$];
   logic [113:0] all_out;
   int checks = 0, errors = 0;
   mem_stage dut (
      .reloj(reloj), .resetMEM(resetMEM), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .w_h(w_h),
      .ctrl_WB_mem(ctrl_WB_mem), .DIR(DIR), .DI(DI), .Y_MUX_mem(Y_MUX_mem),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
      .ctrl_WB_wb(ctrl_WB_wb), .DO_wb(DO_wb), .DIR_wb(DIR_wb), .Y_MUX_wb(Y_MUX_wb),
      .misalign(misalign), .bus_err(bus_err)
   );
   always #5 reloj = ~reloj;
   assign wb_now  = {ctrl_WB_wb, DO_wb, DIR_wb, Y_MUX_wb};
   assign all_out = {mem_req, mem_we, mem_addr, mem_wdata, mem_be, wb_now, misalign, bus_err};
   task automatic check(input string tag, input logic [113:0] got, input logic [113:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic nxt();
      @(posedge reloj);
      #1;
   endtask
   task automatic set_in(input logic rd, input logic wr, input logic wh, input logic [1:0] ctrl,
                         input logic [31:0] dir, input logic [31:0] di, input logic [4:0] y);
      MEM_RD = rd; MEM_WR = wr; w_h = wh; ctrl_WB_mem = ctrl; DIR = dir; DI = di; Y_MUX_mem = y;
   endtask
   task automatic mem_op(input logic rd, input logic wr, input logic wh, input logic [1:0] ctrl,
                         input logic [31:0] dir, input logic [31:0] di, input logic [4:0] y,
                         input int waits, input logic [31:0] rdata);
      logic [15:0] h;
      logic [31:0] exp_do, exp_wd;
      logic [3:0]  exp_be;
      int stalls;
      set_in(rd, wr, wh, ctrl, dir, di, y);
      mem_ack = 1'b0;
      h      = dir[1] ? rdata[31:16] : rdata[15:0];
      exp_do = wr ? 32'd0 : (wh ? {{16{h[15]}}, h} : rdata);
      exp_be = (wr & wh) ? (dir[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      exp_wd = wh ? {di[15:0], di[15:0]} : di;
      sb.push_back({ctrl, exp_do, dir, y});
      stalls = 0;
      @(negedge reloj);
      stalls += int'(stall);
      nxt();
      check("req", 114'(mem_req), 114'(1'b1));
      check("addr", 114'(mem_addr), 114'({dir[31:2], 2'b00}));
      check("be", 114'(mem_be), 114'(exp_be));
      check("we", 114'(mem_we), 114'(wr));
      if (wr) check("wdata", 114'(mem_wdata), 114'(exp_wd));
      repeat (waits) begin
         mem_rdata = $urandom;
         @(negedge reloj);
         stalls += int'(stall);
         nxt();
      end
      mem_ack = 1'b1;
      mem_rdata = rdata;
      @(negedge reloj);
      check("ack_stall", 114'(stall), 114'(1'b0));
      nxt();
      mem_ack = 1'b0;
      set_in(0, 0, 0, 2'b00, 32'd0, 32'd0, 5'd0);
      check("stall_cycles", 114'(stalls), 114'(waits + 1));
      check("req_done", 114'(mem_req), 114'(1'b0));
      check("no_bus_err", 114'(bus_err), 114'(1'b0));
      check("wb", 114'(wb_now), 114'(sb.pop_front()));
   endtask
   task automatic plain_op(input logic rd, input logic wr, input logic wh, input logic [1:0] ctrl,
                           input logic [31:0] dir, input logic [4:0] y);
      logic acc;
      acc = rd | wr;
      set_in(rd, wr, wh, ctrl, dir, 32'h5555_aaaa, y);
      sb.push_back({acc ? 2'b00 : ctrl, 32'd0, dir, y});
      @(negedge reloj);
      check("plain_stall", 114'(stall), 114'(1'b0));
      nxt();
      set_in(0, 0, 0, 2'b00, 32'd0, 32'd0, 5'd0);
      check("plain_req", 114'(mem_req), 114'(1'b0));
      check("misalign", 114'(misalign), 114'(acc));
      check("plain_wb", 114'(wb_now), 114'(sb.pop_front()));
      nxt();
      check("misalign_end", 114'(misalign), 114'(1'b0));
   endtask
   initial begin
      int n;
      mem_ack = 1'b0;
      mem_rdata = 32'd0;
      resetMEM = 1'b1;
      set_in(1, 0, 0, 2'b11, 32'h10, 32'd0, 5'd1);
      @(negedge reloj);
      check("reset_stall", 114'(stall), 114'(1'b0));
      nxt();
      check("reset_outs", all_out, 114'd0);
      resetMEM = 1'b0;
      set_in(0, 0, 0, 2'b00, 32'd0, 32'd0, 5'd0);
      nxt();
      mem_op(1, 0, 0, 2'b11, 32'h10, 32'd0, 5'd3, 2, 32'hDEADBEEF);
      mem_op(0, 1, 1, 2'b01, 32'h22, 32'h0000ABCD, 5'd4, 0, 32'h0);
      mem_op(0, 1, 1, 2'b01, 32'h20, 32'h1234_5678, 5'd4, 1, 32'h0);
      mem_op(1, 0, 1, 2'b10, 32'h06, 32'd0, 5'd5, 1, 32'h8001_1234);
      mem_op(1, 0, 1, 2'b10, 32'h04, 32'd0, 5'd6, 0, 32'h8001_1234);
      mem_op(0, 1, 0, 2'b01, 32'h100, 32'h1234_5678, 5'd7, 0, 32'h0);
      mem_op(1, 1, 0, 2'b11, 32'h104, 32'hCAFE_F00D, 5'd8, 1, 32'hFFFF_FFFF);
      mem_ack = 1'b1;
      plain_op(0, 0, 0, 2'b10, 32'h1234_0000, 5'd9);
      mem_ack = 1'b0;
      plain_op(1, 0, 0, 2'b11, 32'h13, 5'd10);
      plain_op(0, 1, 1, 2'b01, 32'h21, 5'd11);
      // no ack: expect 255 stalled BUSY cycles then a bus error
      set_in(1, 0, 0, 2'b11, 32'h40, 32'd0, 5'd12);
      sb.push_back({2'b00, 32'd0, 32'h40, 5'd12});
      @(negedge reloj);
      nxt();
      n = 0;
      while (n < 300) begin
         @(negedge reloj);
         if (!stall) break;
         n++;
         nxt();
      end
      check("timeout_cycles", 114'(n), 114'(255));
      nxt();
      set_in(0, 0, 0, 2'b00, 32'd0, 32'd0, 5'd0);
      check("bus_err", 114'(bus_err), 114'(1'b1));
      check("to_req", 114'(mem_req), 114'(1'b0));
      check("to_wb", 114'(wb_now), 114'(sb.pop_front()));
      nxt();
      check("bus_err_end", 114'(bus_err), 114'(1'b0));
      mem_op(1, 0, 0, 2'b11, 32'h44, 32'd0, 5'd13, 255, 32'h0BAD_F00D);
      set_in(1, 0, 0, 2'b11, 32'h80, 32'd0, 5'd14);
      @(negedge reloj);
      nxt();
      nxt();
      resetMEM = 1'b1;
      @(negedge reloj);
      check("rst_busy_stall", 114'(stall), 114'(1'b0));
      nxt();
      resetMEM = 1'b0;
      set_in(0, 0, 0, 2'b00, 32'd0, 32'd0, 5'd0);
      check("rst_busy_outs", all_out, 114'd0);
      nxt();
      mem_ack = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      nxt();
      mem_ack = 1'b0;
      check("late_ack_outs", all_out, 114'd0);
      mem_op(1, 0, 0, 2'b01, 32'h84, 32'd0, 5'd15, 1, 32'h0102_0304);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
   initial begin
      #20000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
endmodule
